// File: rtl/ysyx_2022040010_shift_issue_pkg.sv
// Shared constants and helpers for the RV64I shift issue/retire wrapper.
package ysyx_2022040010_shift_issue_pkg;

  localparam int XLEN = 64;

  // One-hot shift-unit operation codes
  localparam logic [2:0] SH_OP_SLL  = 3'b100;
  localparam logic [2:0] SH_OP_SRL  = 3'b010;
  localparam logic [2:0] SH_OP_SRA  = 3'b001;
  localparam logic [2:0] SH_OP_NONE = 3'b000;

  // funct3 encodings of the shift instructions
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // RV64 W-form result: sign-extend the low word to 64 bits
  function automatic logic [63:0] sext_word(input logic [63:0] value);
    return {{32{value[31]}}, value[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_2022040010_shift_decode.sv
// Combinational decode of a shift instruction into shift-unit operands:
// one-hot op, illegal flag, pre-extended source and masked amount.
module ysyx_2022040010_shift_decode
  import ysyx_2022040010_shift_issue_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [2:0]      sh_op,
  output logic            illegal,
  output logic [XLEN-1:0] sh_src,
  output logic [XLEN-1:0] sh_amount
);

  // Only the low six amount bits are architecturally meaningful
  logic unused_src2_s;
  assign unused_src2_s = ^src2[XLEN-1:6];

  // Select the operation from funct3 / bit30
  always_comb begin
    sh_op = SH_OP_NONE;
    case (funct3)
      F3_SLL: begin
        if (!funct7_5) begin
          sh_op = SH_OP_SLL;
        end else begin
          sh_op = SH_OP_NONE;
        end
      end
      F3_SR: begin
        if (funct7_5) begin
          sh_op = SH_OP_SRA;
        end else begin
          sh_op = SH_OP_SRL;
        end
      end
      default: sh_op = SH_OP_NONE;
    endcase
  end

  // Illegal encodings feed zero operands so the shifter sees a quiet input
  always_comb begin
    illegal   = (sh_op == SH_OP_NONE);
    sh_src    = {XLEN{1'b0}};
    sh_amount = {XLEN{1'b0}};
    if (!illegal) begin
      if (word) begin
        sh_amount = {59'b0, src2[4:0]};
      end else begin
        sh_amount = {58'b0, src2[5:0]};
      end
      case ({word, sh_op})
        {1'b1, SH_OP_SRL}: sh_src = {32'b0, src1[31:0]};
        {1'b1, SH_OP_SRA}: sh_src = {{32{src1[31]}}, src1[31:0]};
        default:           sh_src = src1;
      endcase
    end else begin
      sh_src    = {XLEN{1'b0}};
      sh_amount = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/ysyx_2022040010_shift_issue.sv
// Two-slot EX wrapper around an external combinational 64-bit shifter.
// S1 holds decoded operands that drive the shifter; S2 holds the extended
// result presented to MEM. Handshakes are valid/ready with no skid buffer.
module ysyx_2022040010_shift_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] sh_src,
  output logic [XLEN-1:0] sh_amount,
  output logic [2:0]      sh_op,
  output logic            sh_alu32,
  input  logic [XLEN-1:0] sh_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  import ysyx_2022040010_shift_issue_pkg::*;

  logic [2:0]      dec_op_s;
  logic            dec_illegal_s;
  logic [XLEN-1:0] dec_src_s;
  logic [XLEN-1:0] dec_amount_s;

  logic            s1_valid_r;
  logic [2:0]      s1_op_r;
  logic            s1_illegal_r;
  logic            s1_word_r;
  logic [XLEN-1:0] s1_src_r;
  logic [XLEN-1:0] s1_amount_r;
  logic [4:0]      s1_rd_r;

  logic            s2_valid_r;
  logic [XLEN-1:0] s2_data_r;
  logic [4:0]      s2_rd_r;
  logic            s2_illegal_r;

  logic            s2_free_s;
  logic            s1_adv_s;
  logic            in_fire_s;
  logic [XLEN-1:0] s2_data_next_s;

  ysyx_2022040010_shift_decode u_decode (
    .funct3    (in_funct3),
    .funct7_5  (in_funct7_5),
    .word      (in_word),
    .src1      (in_src1),
    .src2      (in_src2),
    .sh_op     (dec_op_s),
    .illegal   (dec_illegal_s),
    .sh_src    (dec_src_s),
    .sh_amount (dec_amount_s)
  );

  assign s2_free_s = !s2_valid_r | out_ready;
  assign s1_adv_s  = s1_valid_r & s2_free_s;
  assign in_ready  = !s1_valid_r | s1_adv_s;
  assign in_fire_s = in_valid & in_ready & !flush;

  // Extend the shifter result; illegal entries retire with zero data
  always_comb begin
    s2_data_next_s = {XLEN{1'b0}};
    if (s1_illegal_r) begin
      s2_data_next_s = {XLEN{1'b0}};
    end else if (s1_word_r) begin
      s2_data_next_s = sext_word(sh_result);
    end else begin
      s2_data_next_s = sh_result;
    end
  end

  // S1 slot: capture decoded operands on an accepted input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_op_r      <= SH_OP_NONE;
      s1_illegal_r <= 1'b0;
      s1_word_r    <= 1'b0;
      s1_src_r     <= {XLEN{1'b0}};
      s1_amount_r  <= {XLEN{1'b0}};
      s1_rd_r      <= 5'd0;
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (in_ready) begin
        s1_valid_r <= in_valid;
      end
      if (in_fire_s) begin
        s1_op_r      <= dec_op_s;
        s1_illegal_r <= dec_illegal_s;
        s1_word_r    <= in_word;
        s1_src_r     <= dec_src_s;
        s1_amount_r  <= dec_amount_s;
        s1_rd_r      <= in_rd;
      end
    end
  end

  // S2 slot: capture the extended result when S1 advances; hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r   <= 1'b0;
      s2_data_r    <= {XLEN{1'b0}};
      s2_rd_r      <= 5'd0;
      s2_illegal_r <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid_r <= 1'b0;
      end else if (s2_free_s) begin
        s2_valid_r <= s1_valid_r;
      end
      if (s1_adv_s) begin
        s2_data_r    <= s2_data_next_s;
        s2_rd_r      <= s1_rd_r;
        s2_illegal_r <= s1_illegal_r;
      end
    end
  end

  assign sh_src      = s1_src_r;
  assign sh_amount   = s1_amount_r;
  assign sh_op       = s1_op_r;
  assign sh_alu32    = s1_word_r;

  assign out_valid   = s2_valid_r;
  assign out_data    = s2_data_r;
  assign out_rd      = s2_rd_r;
  assign out_illegal = s2_illegal_r;

endmodule
